// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} hex table,
// blank pattern and the arbiter FSM state type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_e;

endpackage

// File: rtl/seven_seg_arbiter_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter sharing the SEVEN_SEG PIO: decodes the winner's digit,
// issues a one-cycle Avalon-MM write, then holds the display for HOLD_CYCLES.
module seven_seg_arbiter
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_digit,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 avm_chipselect,
    output logic [1:0]           avm_address,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 shown_blank_q, shown_blank_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cs_q, cs_d;
    logic                 write_n_q, write_n_d;
    logic [31:0]          wdata_q, wdata_d;

    logic                 found;
    logic [PTR_W-1:0]     win;
    int unsigned          idx;
    logic [3:0]           win_digit;
    logic [6:0]           win_seg;

    // Rotating priority: scan from rr_ptr+1 upward, wrapping mod NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign win_digit = req_digit[{win, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .digit_i (win_digit),
        .seg_o   (win_seg)
    );

    // Strobes are computed for the next cycle so the bus sees registered outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        shown_blank_d = shown_blank_q;
        cnt_d         = cnt_q;
        cs_d          = 1'b0;
        write_n_d     = 1'b1;
        wdata_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = WRITE;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    rr_ptr_d     = win;
                    cs_d         = 1'b1;
                    write_n_d    = 1'b0;
                    wdata_d      = {25'b0, win_seg};
                end else if (!shown_blank_q) begin
                    state_d   = WRITE;
                    grant_d   = '0;
                    cs_d      = 1'b1;
                    write_n_d = 1'b0;
                    wdata_d   = {25'b0, SEG_BLANK};
                end
            end
            WRITE: begin
                // An empty grant marks the blank write, which skips HOLD.
                if (grant_q != '0) begin
                    state_d       = HOLD;
                    cnt_d         = '0;
                    shown_blank_d = 1'b0;
                end else begin
                    state_d       = IDLE;
                    shown_blank_d = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            shown_blank_q <= 1'b0;
            cnt_q         <= '0;
            cs_q          <= 1'b0;
            write_n_q     <= 1'b1;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            shown_blank_q <= shown_blank_d;
            cnt_q         <= cnt_d;
            cs_q          <= cs_d;
            write_n_q     <= write_n_d;
            wdata_q       <= wdata_d;
        end
    end

    assign grant          = grant_q;
    assign busy           = (state_q != IDLE);
    assign avm_chipselect = cs_q;
    assign avm_address    = 2'b00;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Directed bench for seven_seg_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_seven_seg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_digit;
    logic [3:0]  grant;
    logic        busy;
    logic        avm_chipselect;
    logic [1:0]  avm_address;
    logic        avm_write_n;
    logic [31:0] avm_writedata;

    logic [3:0]  dec_digit;
    logic [6:0]  dec_seg;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_exp [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    seven_seg_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (4),
        .CNT_W       (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_digit      (req_digit),
        .grant          (grant),
        .busy           (busy),
        .avm_chipselect (avm_chipselect),
        .avm_address    (avm_address),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata)
    );

    hex_to_seg u_dec (
        .digit_i (dec_digit),
        .seg_o   (dec_seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advances negedges until a write strobe is seen; n is cycles waited.
    task automatic wait_write(output int n, output logic [31:0] d, output logic [3:0] g,
                              input int budget);
        n = 0;
        d = '0;
        g = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_chipselect && !avm_write_n) && n < budget);
        d = avm_writedata;
        g = grant;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          wcount;
        int          bc;
        logic [31:0] d;
        logic [3:0]  g;

        reset     = 1'b1;
        req       = '0;
        req_digit = '0;
        repeat (2) @(negedge clk);
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_cs",      32'(avm_chipselect), 32'h0);
        check("rst_wn",      32'(avm_write_n), 32'h1);
        check("rst_addr",    32'(avm_address), 32'h0);
        check("rst_wdata",   avm_writedata, 32'h0);

        // First blank write after reset, then quiet idle
        reset = 1'b0;
        wait_write(n, d, g, 20);
        check("blank_lat",   32'(n), 32'd1);
        check("blank_data",  d, 32'h7F);
        check("blank_grant", 32'(g), 32'h0);
        @(negedge clk);
        check("idle_busy",   32'(busy), 32'h0);
        wcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) wcount++;
        end
        check("idle_nowrite", 32'(wcount), 32'd0);

        // Single continuous requester 1, digit 3
        req       = 4'b0010;
        req_digit = 16'h0030;
        wait_write(n, d, g, 20);
        check("r1_lat",   32'(n), 32'd1);
        check("r1_data",  d, 32'h30);
        check("r1_grant", 32'(g), 32'b0010);
        check("r1_addr",  32'(avm_address), 32'h0);
        bc = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        check("r1_busy_len", 32'(bc), 32'd5);
        check("r1_idle_cs",  32'(avm_chipselect), 32'h0);
        wait_write(n, d, g, 20);
        check("r1_rewr_lat",  32'(n), 32'd1);
        check("r1_rewr_data", d, 32'h30);
        wait_write(n, d, g, 20);
        check("r1_period",    32'(n), 32'd6);
        check("r1_per_data",  d, 32'h30);

        // Two requesters alternate: rr_ptr=1, so req2 (A) wins first
        req       = 4'b0101;
        req_digit = 16'h0A08;
        for (int i = 0; i < 4; i++) begin
            wait_write(n, d, g, 20);
            check("alt_period", 32'(n), 32'd6);
            check("alt_data",   d, (i % 2 == 0) ? 32'h08 : 32'h00);
            check("alt_grant",  32'(g), (i % 2 == 0) ? 32'b0100 : 32'b0001);
        end

        // Requests drop: blank write after the hold
        req = '0;
        wait_write(n, d, g, 20);
        check("drop_period", 32'(n), 32'd6);
        check("drop_blank",  d, 32'h7F);
        check("drop_grant",  32'(g), 32'h0);
        @(negedge clk);

        // One-cycle pulse on req3 still gets the full hold
        req       = 4'b1000;
        req_digit = 16'hF000;
        @(negedge clk);
        check("p3_strobe", 32'({avm_chipselect, avm_write_n}), 32'b10);
        check("p3_data",   avm_writedata, 32'h0E);
        check("p3_grant",  32'(grant), 32'b1000);
        req       = '0;
        req_digit = 16'h1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("p3_hold_grant", 32'(grant), 32'b1000);
            check("p3_hold_busy",  32'(busy), 32'h1);
            check("p3_hold_cs",    32'(avm_chipselect), 32'h0);
        end
        @(negedge clk);
        check("p3_idle_grant", 32'(grant), 32'h0);
        check("p3_idle_busy",  32'(busy), 32'h0);
        wait_write(n, d, g, 20);
        check("p3_blank_lat",  32'(n), 32'd1);
        check("p3_blank_data", d, 32'h7F);
        @(negedge clk);

        // Async reset during the second HOLD cycle
        req       = 4'b0010;
        req_digit = 16'h0030;
        wait_write(n, d, g, 20);
        check("ar_data", d, 32'h30);
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_grant", 32'(grant), 32'b0010);
        reset = 1'b1;
        #1;
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_wn",    32'(avm_write_n), 32'h1);
        check("ar_cs",    32'(avm_chipselect), 32'h0);
        check("ar_busy",  32'(busy), 32'h0);
        req       = 4'b0011;
        req_digit = 16'h0031;
        @(negedge clk);
        reset = 1'b0;
        wait_write(n, d, g, 20);
        check("ar_first_lat",   32'(n), 32'd1);
        check("ar_first_data",  d, 32'h79);
        check("ar_first_grant", 32'(g), 32'b0001);
        wait_write(n, d, g, 20);
        check("ar_next_lat",    32'(n), 32'd6);
        check("ar_next_data",   d, 32'h30);
        check("ar_next_grant",  32'(g), 32'b0010);

        // Decoder table sweep
        for (int i = 0; i < 16; i++) begin
            dec_digit = 4'(i);
            #1;
            check("hex_to_seg", 32'(dec_seg), 32'(seg_exp[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
